// File: rtl/custom_types_pkg.sv
// Shared pipeline bundle types and memory-stage helpers.
// Combinational helpers only; no state lives here.
// Used by the memory stage and anything that inspects its bundles.
package custom_types_pkg;

    // Execute -> memory bundle
    typedef struct packed {
        logic [4:0]  Rt;
        logic [4:0]  Rd;
        logic [4:0]  Rw;
        logic        RegWEN;
        logic        MemtoReg;
        logic        halt;
        logic        dREN;
        logic        dWEN;
        logic [31:0] NPC;
        logic [31:0] port_o;
        logic [31:0] port_b;
        logic [31:0] Imm_Ext;
    } execute_t;

    // Memory -> writeback bundle
    typedef struct packed {
        logic [4:0]  Rt;
        logic [4:0]  Rd;
        logic [4:0]  Rw;
        logic        RegWEN;
        logic        MemtoReg;
        logic        halt;
        logic [31:0] NPC;
        logic [31:0] port_o;
        logic [31:0] Imm_Ext;
        logic [31:0] dmemload;
    } memory_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PASS   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HALTED = 2'd3
    } mem_state_t;

    // State an incoming instruction puts the stage into once latched
    function automatic mem_state_t capture_state(input logic vld, input execute_t e);
        if (!vld)
            return ST_IDLE;
        else if (e.dREN || e.dWEN)
            return ST_WAIT;
        else
            return ST_PASS;
    endfunction

    // Build the writeback bundle; load data is already zeroed for non-loads
    function automatic memory_t to_memory(input execute_t e, input logic [31:0] ld);
        memory_t m;
        m.Rt       = e.Rt;
        m.Rd       = e.Rd;
        m.Rw       = e.Rw;
        m.RegWEN   = e.RegWEN;
        m.MemtoReg = e.MemtoReg;
        m.halt     = e.halt;
        m.NPC      = e.NPC;
        m.port_o   = e.port_o;
        m.Imm_Ext  = e.Imm_Ext;
        m.dmemload = ld;
        return m;
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM latch, dcache request drive, registered writeback bundle.
// Latency: non-memory op 1 cycle after capture; memory op 1 cycle after dhit.
// Backpressure: stall_o held combinationally while a latched load/store awaits dhit.
module mem_stage
    import custom_types_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  execute_t               ex_in,
    input  logic                   ex_valid,
    input  logic                   dhit,
    input  logic [31:0]            dmemload,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output logic [31:0]            dmemaddr,
    output logic [31:0]            dmemstore,
    output memory_t                mem_out,
    output logic                   mem_valid,
    output logic                   stall_o,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    mem_state_t             r_state;
    execute_t               r_req;
    memory_t                r_mem_out;
    logic                   r_mem_valid;
    logic                   r_halted;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    logic        w_wait;
    logic        w_retire;
    logic        w_capture;
    logic [31:0] w_load_data;

    // Requests and stall come straight from state so a reset drops them at once
    assign w_wait    = (r_state == ST_WAIT);
    assign dmemREN   = w_wait & r_req.dREN & ~r_req.dWEN;
    assign dmemWEN   = w_wait & r_req.dWEN;
    assign dmemaddr  = r_req.port_o;
    assign dmemstore = r_req.port_b;
    assign stall_o   = w_wait & ~dhit;

    // An instruction leaves the latch when it needs no memory or memory answered
    assign w_retire    = (r_state == ST_PASS) | (w_wait & dhit);
    assign w_capture   = ~stall_o & (r_state != ST_HALTED);
    // Both-enables case is a store, so it carries no load data
    assign w_load_data = (w_wait && !r_req.dWEN) ? dmemload : 32'h0;

    assign mem_out      = r_mem_out;
    assign mem_valid    = r_mem_valid;
    assign halted       = r_halted;
    assign stall_cycles = r_stall_cycles;

    // Stage FSM: retire the latched op, then latch the next one unless halting
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_mem_out   <= '0;
            r_mem_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            if (w_retire) begin
                r_mem_out   <= to_memory(r_req, w_load_data);
                r_mem_valid <= 1'b1;
            end else begin
                r_mem_valid <= 1'b0;
            end

            if (w_retire && r_req.halt) begin
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
            end else if (w_capture) begin
                r_req   <= ex_in;
                r_state <= capture_state(ex_valid, ex_in);
            end
        end
    end

    // Saturating count of cycles spent holding the pipeline
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_stall_cycles <= '0;
        else if (stall_o && (r_stall_cycles != {STALL_CNT_W{1'b1}}))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

endmodule
